// File: rtl/rgb_fade_pwm.sv
// RGB LED driver: per-channel intensity fades toward the colour target and is
// rendered as PWM against a free-running counter.
module rgb_fade_pwm #(
   parameter int unsigned PWM_W    = 8,
   parameter int unsigned FADE_DIV = 4,
   parameter int unsigned STEP     = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] colour,
   output logic       led_r,
   output logic       led_g,
   output logic       led_b,
   output logic       busy
);

   localparam int unsigned DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

   typedef enum logic {IDLE, FADING} state_t;

   state_t             state, state_next;
   logic [2:0]         colour_q;
   logic [PWM_W-1:0]   level_r, level_g, level_b;
   logic [PWM_W-1:0]   level_r_next, level_g_next, level_b_next;
   logic [PWM_W-1:0]   tgt_r, tgt_g, tgt_b;
   logic [PWM_W-1:0]   pwm_cnt;
   logic [DIV_W-1:0]   div_cnt, div_next;
   logic               do_step;

   // One fade step toward tgt; sums are one bit wider so the clamp sees overflow.
   function automatic logic [PWM_W-1:0] step_level(input logic [PWM_W-1:0] lvl,
                                                   input logic [PWM_W-1:0] tgt);
      logic [PWM_W:0] up;
      logic [PWM_W:0] dn;
      up = {1'b0, lvl} + (PWM_W+1)'(STEP);
      dn = {1'b0, lvl} - (PWM_W+1)'(STEP);
      step_level = lvl;
      if (lvl < tgt)
         step_level = (up > {1'b0, tgt}) ? tgt : up[PWM_W-1:0];
      else if (lvl > tgt)
         step_level = (dn[PWM_W] || (dn[PWM_W-1:0] < tgt)) ? tgt : dn[PWM_W-1:0];
   endfunction

   assign tgt_r = {PWM_W{colour_q[0]}};
   assign tgt_g = {PWM_W{colour_q[1]}};
   assign tgt_b = {PWM_W{colour_q[2]}};

   // Next-state, step and divider logic
   always_comb begin
      state_next   = state;
      div_next     = '0;
      do_step      = 1'b0;
      level_r_next = level_r;
      level_g_next = level_g;
      level_b_next = level_b;
      case (state)
         IDLE: begin
            if ((level_r != tgt_r) || (level_g != tgt_g) || (level_b != tgt_b))
               state_next = FADING;
         end
         FADING: begin
            do_step = (div_cnt == DIV_W'(FADE_DIV - 1));
            if (do_step) begin
               level_r_next = step_level(level_r, tgt_r);
               level_g_next = step_level(level_g, tgt_g);
               level_b_next = step_level(level_b, tgt_b);
            end
            // Leave as soon as the step just taken lands every channel on target.
            if ((level_r_next == tgt_r) && (level_g_next == tgt_g) &&
                (level_b_next == tgt_b)) begin
               state_next = IDLE;
            end else begin
               div_next = do_step ? '0 : div_cnt + DIV_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         colour_q <= '0;
         level_r  <= '0;
         level_g  <= '0;
         level_b  <= '0;
         pwm_cnt  <= '0;
         div_cnt  <= '0;
         led_r    <= 1'b0;
         led_g    <= 1'b0;
         led_b    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_next;
         colour_q <= colour;
         level_r  <= level_r_next;
         level_g  <= level_g_next;
         level_b  <= level_b_next;
         pwm_cnt  <= pwm_cnt + PWM_W'(1);
         div_cnt  <= div_next;
         led_r    <= (level_r > pwm_cnt);
         led_g    <= (level_g > pwm_cnt);
         led_b    <= (level_b > pwm_cnt);
         busy     <= (state_next == FADING);
      end
   end

endmodule

// File: doc/rgb_fade_pwm.md
Name: rgb_fade_pwm

Overview:
Downstream stage of lightcontrol. Consumes its 3-bit colour output and drives the three physical RGB LED pins. Each channel has an intensity level that ramps smoothly toward its target when colour changes. Each level is rendered as PWM against a free-running counter.

Parameters:
PWM_W, 8, bit width of channel level and PWM counter (period = 2^PWM_W cycles)
FADE_DIV, 4, clock cycles per fade step (>=1)
STEP, 16, level increment/decrement per fade step (1..2^PWM_W-1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
colour  input  3  colour code from lightcontrol; bit0=red, bit1=green, bit2=blue
led_r  output  1  red LED PWM drive, registered
led_g  output  1  green LED PWM drive, registered
led_b  output  1  blue LED PWM drive, registered
busy  output  1  high while any channel level differs from its target, registered

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset, on the edge where rst=1:
  - colour_q=000, level_r/g/b=0, pwm_cnt=0, div_cnt=0.
  - led_r/g/b=0, busy=0, state=IDLE.
  - rst takes priority over every other event, including mid-fade.
- Input register: colour_q <= colour every cycle. All codes 000..111 are legal; 000=off, 111=white.
- Target per channel: MAX=2^PWM_W-1 if its colour_q bit=1, else 0.
- PWM counter:
  - pwm_cnt increments every cycle, wraps MAX->0.
  - Never stalls; not affected by fades.
- LED outputs: led_x <= (level_x > pwm_cnt), using pre-edge values.
  - level 0 -> constant 0.
  - level MAX -> high for MAX of every 2^PWM_W cycles.
- State machine, two states:
  - IDLE: all levels equal targets; div_cnt held at 0. Goes to FADING when any level != target.
  - FADING: div_cnt counts 0..FADE_DIV-1, then wraps. When div_cnt==FADE_DIV-1, each channel takes one step:
    - level<target: level <= min(level+STEP, target).
    - level>target: level <= max(level-STEP, target).
    - level==target: unchanged.
  - FADING returns to IDLE when all levels equal targets; div_cnt is cleared to 0.
- Arithmetic: compute add/sub at PWM_W+1 bits, then clamp to target. No wrap-around or overshoot is permitted.
- busy <= (state_next==FADING).
- Latency from a colour change at the input:
  - colour_q updates at edge E.
  - busy=1 after edge E+1.
  - First level step lands at edge E+1+FADE_DIV.
  - Subsequent steps land every FADE_DIV cycles.
- Colour change mid-fade:
  - Targets update immediately from the new colour_q.
  - Per-channel direction is re-evaluated at the next step.
  - div_cnt is not reset.
  - Levels continue from their current values; no jump.
- Colour toggles back to the current levels before the next step: the FSM returns to IDLE and busy drops.
- Simultaneous events: channels fade independently and in parallel, and may move in opposite directions in the same step.
- Full ramp with defaults: 0->255 or 255->0 takes 16 steps = 64 cycles.
  - Up: 0,16,...,240,255.
  - Down: 255,239,...,15,0.

Test Plan:
1. Reset then colour=001 held: busy rises 2 cycles after colour is applied. level_r reaches 16 after 4 more cycles and 255 after 64 cycles total. busy falls the cycle level_r==255. level_g and level_b stay 0 and led_g/led_b stay 0.
2. Steady colour=111 after the ramp completes: over any 256-cycle window, each of led_r/g/b is high for exactly 255 cycles and all three are identical. colour=000 steady: all LEDs are 0 for 256 cycles.
3. Mid-fade change: colour=001; when level_r==128 apply colour=010. level_r steps 128,112,...,0 (8 steps) while level_g steps 0,16,...,128 in the same steps. busy stays high until level_g==255. No level exceeds 255 or goes below 0.
4. Fade down with clamp: from white (all 255) apply colour=000. Each level goes 255,239,...,15,0 over 16 steps; the last step clamps 15->0, never wrapping to 255. busy=0 afterwards.
5. Reset mid-operation: during a fade at level_r=96, assert rst for 1 cycle. Next cycle: all levels 0, LEDs 0, busy 0, pwm_cnt 0. With colour still 001 after rst drops, the ramp restarts from 0 with the same latency as scenario 1.
6. Parameter check with FADE_DIV=1, STEP=255: colour 000->100 gives level_b=255 one cycle after busy rises. busy is high for exactly 1 cycle.
